// File: rtl/lc3_mem_pkg.sv
// Shared constants for the LC-3 memory controller: MMIO map, FSM encoding, RAM write mask.
package lc3_mem_pkg;

    localparam logic [15:0] MMIO_BASE  = 16'hFE00;
    localparam logic [15:0] KBSR_A     = 16'hFE00;
    localparam logic [15:0] KBDR_A     = 16'hFE02;
    localparam logic [15:0] DSR_A      = 16'hFE04;
    localparam logic [15:0] DDR_A      = 16'hFE06;
    localparam logic [15:0] MCR_A      = 16'hFFFE;
    localparam logic [15:0] WMASK_FULL = 16'hFFFF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RAM_RD = 2'd1;
    localparam logic [1:0] ST_RAM_WR = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 memory-mapped device registers: keyboard (KBSR/KBDR), display (DSR/DDR) and MCR.
module lc3_mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        rd_en,
    input  logic [15:0] rd_addr,
    output logic [15:0] rd_data,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        halt
);

    logic        kbd_full_q, kbd_full_d;
    logic [7:0]  kbd_q, kbd_d;
    logic        ie_q, ie_d;
    logic        dsp_valid_q, dsp_valid_d;
    logic [7:0]  dsp_data_q, dsp_data_d;
    logic [15:0] mcr_q, mcr_d;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
        kbd_full_d  = kbd_full_q;
        kbd_d       = kbd_q;
        ie_d        = ie_q;
        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
        mcr_d       = mcr_q;

        // Capture and KBDR-read clear are exclusive: capture needs kbd_full_q == 0.
        if (kbd_valid && !kbd_full_q) begin
            kbd_full_d = 1'b1;
            kbd_d      = kbd_data;
        end else if (rd_en && rd_addr == KBDR_A) begin
            kbd_full_d = 1'b0;
        end

        if (dsp_valid_q && dsp_ready) begin
            dsp_valid_d = 1'b0;
        end

        if (wr_en) begin
            case (wr_addr)
                KBSR_A: ie_d = wr_data[14];
                DDR_A: begin
                    // Judged on the old pending flag, so a write racing the drain is dropped.
                    if (!dsp_valid_q) begin
                        dsp_valid_d = 1'b1;
                        dsp_data_d  = wr_data[7:0];
                    end
                end
                MCR_A:   mcr_d = wr_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        case (rd_addr)
            KBSR_A:  rd_data = {kbd_full_q, ie_q, 14'b0};
            KBDR_A:  rd_data = {8'h00, kbd_q};
            DSR_A:   rd_data = {~dsp_valid_q, 15'b0};
            MCR_A:   rd_data = mcr_q;
            default: rd_data = 16'h0000;
        endcase
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous, sampled on the clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kbd_full_q  <= 1'b0;
            kbd_q       <= 8'h00;
            ie_q        <= 1'b0;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= 8'h00;
            mcr_q       <= 16'h8000;
        end else begin
            kbd_full_q  <= kbd_full_d;
            kbd_q       <= kbd_d;
            ie_q        <= ie_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
            mcr_q       <= mcr_d;
        end
    end

    assign kbd_ready = ~kbd_full_q;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;
    assign halt      = ~mcr_q[15];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory request controller: routes core accesses to the RAM helper or the local MMIO
// registers and returns exactly one response per accepted request.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter logic [ADDR_W-1:0] MMIO_BASE = lc3_mem_pkg::MMIO_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_we,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] ram_ridx,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_widx,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask,
    output logic              ram_wen,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_data,
    output logic              kbd_ready,
    output logic              dsp_valid,
    output logic [7:0]        dsp_data,
    input  logic              dsp_ready,
    output logic              halt
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              mmio_q, mmio_d;
    logic [ADDR_W-1:0] ridx_q, ridx_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [DATA_W-1:0] rwdata_q, rwdata_d;

    logic              accept;
    logic              req_mmio;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [15:0]       mmio_rdata;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_mmio  = (req_addr >= MMIO_BASE);

    // MMIO writes commit on the accept edge so the ack cycle already reflects them (e.g. halt).
    assign mmio_wr = accept && req_mmio && req_we;
    assign mmio_rd = (state_q == ST_RESP) && mmio_q && !we_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        mmio_d   = mmio_q;
        ridx_d   = ridx_q;
        widx_d   = widx_q;
        rwdata_d = rwdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    we_d   = req_we;
                    mmio_d = req_mmio;
                    if (req_mmio) begin
                        state_d = ST_RESP;
                    end else if (req_we) begin
                        state_d  = ST_RAM_WR;
                        widx_d   = req_addr;
                        rwdata_d = req_wdata;
                    end else begin
                        state_d = ST_RAM_RD;
                        ridx_d  = req_addr;
                    end
                end
            end
            ST_RAM_RD: state_d = ST_RESP;
            ST_RAM_WR: state_d = ST_IDLE;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            mmio_q   <= 1'b0;
            ridx_q   <= '0;
            widx_q   <= '0;
            rwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            mmio_q   <= mmio_d;
            ridx_q   <= ridx_d;
            widx_q   <= widx_d;
            rwdata_q <= rwdata_d;
        end
    end

    // rst_n gates the strobes so a reset cycle never writes RAM or emits a response.
    assign ram_wen    = rst_n && (state_q == ST_RAM_WR);
    assign ram_wmask  = ram_wen ? WMASK_FULL : '0;
    assign resp_valid = rst_n && (state_q == ST_RAM_WR || state_q == ST_RESP);
    assign ram_ridx   = ridx_q;
    assign ram_widx   = widx_q;
    assign ram_wdata  = rwdata_q;

    always_comb begin
        resp_rdata = '0;
        if (rst_n && state_q == ST_RESP && !we_q) begin
            resp_rdata = mmio_q ? mmio_rdata : ram_rdata;
        end
    end

    lc3_mmio_regs u_mmio (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (mmio_wr),
        .wr_addr   (req_addr),
        .wr_data   (req_wdata),
        .rd_en     (mmio_rd),
        .rd_addr   (addr_q),
        .rd_data   (mmio_rdata),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready),
        .halt      (halt)
    );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: scoreboard of expected responses plus per-feature tasks.
module tb_lc3_mem_ctrl;
    import lc3_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        req_we = 1'b0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [15:0] ram_ridx;
    logic [15:0] ram_rdata = 16'h0000;
    logic [15:0] ram_widx;
    logic [15:0] ram_wdata;
    logic [15:0] ram_wmask;
    logic        ram_wen;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        kbd_ready;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready = 1'b0;
    logic        halt;

    lc3_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_we     (req_we),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .ram_ridx   (ram_ridx),
        .ram_rdata  (ram_rdata),
        .ram_widx   (ram_widx),
        .ram_wdata  (ram_wdata),
        .ram_wmask  (ram_wmask),
        .ram_wen    (ram_wen),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .dsp_valid  (dsp_valid),
        .dsp_data   (dsp_data),
        .dsp_ready  (dsp_ready),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM helper: unwritten words read as a fixed pattern (a*3)^16'hA5C3.
    logic [15:0] mem [0:65535];
    bit          written [0:65535];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a * 16'd3) ^ 16'hA5C3;
    endfunction

    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_widx]     <= ((written[ram_widx] ? mem[ram_widx] : init_val(ram_widx)) & ~ram_wmask)
                                 | (ram_wdata & ram_wmask);
            written[ram_widx] <= 1'b1;
        end
        ram_rdata <= written[ram_ridx] ? mem[ram_ridx] : init_val(ram_ridx);
    end

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   wen_cnt = 0;

    // Response monitor: every resp_valid pops one expectation and checks data and arrival cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ram_wen) wen_cnt++;
            if (resp_valid) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL unexpected_resp: got resp_valid rdata=%h at cycle %0d, required no response",
                             resp_rdata, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (resp_rdata !== e.rdata || cyc != e.cyc)
                        $display("FAIL %s: got rdata=%h cycle=%0d, required rdata=%h cycle=%0d",
                                 e.name, resp_rdata, cyc, e.rdata, e.cyc);
                    else
                        n_pass++;
                end
            end
        end
    end

    // Drive one request, push its expected response (lat = cycles from accept to response).
    task automatic do_req(input logic [15:0] a, input logic we, input logic [15:0] wd,
                          input logic [15:0] exp, input int lat, input string name);
        bit acc = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                sb_q.push_back('{exp, cyc + lat, name});
                break;
            end
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL %s_accept: req_ready never rose within 20 cycles, required acceptance", name);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0)
            $display("FAIL %s_busy: got req_ready=%b after accept, required 0", name, req_ready);
        else
            n_pass++;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL %s_drain: got %0d outstanding responses, required 0", name, sb_q.size());
            sb_q.delete();
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, kbd_ready, resp_valid, ram_wen, dsp_valid, halt} !== 6'b110000)
            $display("FAIL reset_ctrl: got rdy/krdy/rv/wen/dv/halt=%b, required 110000",
                     {req_ready, kbd_ready, resp_valid, ram_wen, dsp_valid, halt});
        else
            n_pass++;
        n_checks++;
        if ({resp_rdata, ram_wmask, ram_ridx, ram_widx, ram_wdata} !== 80'h0)
            $display("FAIL reset_data: got rdata/wmask/ridx/widx/wdata=%h, required 0",
                     {resp_rdata, ram_wmask, ram_ridx, ram_widx, ram_wdata});
        else
            n_pass++;
        n_checks++;
        if (dsp_data !== 8'h00)
            $display("FAIL reset_dsp_data: got %h, required 00", dsp_data);
        else
            n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_ram_write_read();
        wen_cnt = 0;
        do_req(16'h3000, 1'b1, 16'hBEEF, 16'h0000, 1, "wr_3000");
        n_checks++;
        if ({ram_wen, ram_widx, ram_wdata, ram_wmask} !== {1'b1, 16'h3000, 16'hBEEF, 16'hFFFF})
            $display("FAIL wr_ram_port: got wen=%b widx=%h wdata=%h wmask=%h, required 1 3000 BEEF FFFF",
                     ram_wen, ram_widx, ram_wdata, ram_wmask);
        else
            n_pass++;
        drain("wr_3000");
        do_req(16'h3000, 1'b0, 16'h0000, 16'hBEEF, 2, "rd_3000");
        drain("rd_3000");
        n_checks++;
        if (wen_cnt != 1)
            $display("FAIL wen_pulse: got ram_wen high for %0d cycles, required 1", wen_cnt);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        int c0 = -100;
        int c1 = -200;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                c0 = cyc;
                sb_q.push_back('{16'hA5C3, cyc + 2, "b2b_rd0"});
                break;
            end
        end
        @(posedge clk); #1;
        req_addr = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                c1 = cyc;
                sb_q.push_back('{16'hA5C0, cyc + 2, "b2b_rd1"});
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (c1 - c0 != 3)
            $display("FAIL b2b_spacing: got accepts %0d cycles apart, required 3", c1 - c0);
        else
            n_pass++;
        drain("b2b");
    endtask

    task automatic test_keyboard();
        n_checks++;
        if (kbd_ready !== 1'b1) $display("FAIL kbd_ready_idle: got %b, required 1", kbd_ready);
        else n_pass++;
        @(posedge clk); #1;
        kbd_valid = 1'b1; kbd_data = 8'h41;
        @(posedge clk); #1;
        kbd_valid = 1'b0; kbd_data = 8'h00;
        @(negedge clk);
        n_checks++;
        if (kbd_ready !== 1'b0) $display("FAIL kbd_ready_full: got %b, required 0", kbd_ready);
        else n_pass++;
        do_req(KBSR_A, 1'b0, 16'h0000, 16'h8000, 1, "kbsr_full");
        do_req(KBDR_A, 1'b0, 16'h0000, 16'h0041, 1, "kbdr_read");
        do_req(KBSR_A, 1'b0, 16'h0000, 16'h0000, 1, "kbsr_empty");
        drain("kbd");
        n_checks++;
        if (kbd_ready !== 1'b1) $display("FAIL kbd_ready_again: got %b, required 1", kbd_ready);
        else n_pass++;
        // Only the interrupt-enable bit of KBSR is writable.
        do_req(KBSR_A, 1'b1, 16'hFFFF, 16'h0000, 1, "kbsr_wr");
        do_req(KBSR_A, 1'b0, 16'h0000, 16'h4000, 1, "kbsr_ie");
        drain("kbsr_ie");
    endtask

    task automatic test_display();
        dsp_ready = 1'b0;
        do_req(DDR_A, 1'b1, 16'h0048, 16'h0000, 1, "ddr_wr_48");
        n_checks++;
        if ({dsp_valid, dsp_data} !== {1'b1, 8'h48})
            $display("FAIL dsp_pending: got valid=%b data=%h, required 1 48", dsp_valid, dsp_data);
        else
            n_pass++;
        do_req(DSR_A, 1'b0, 16'h0000, 16'h0000, 1, "dsr_busy");
        do_req(DDR_A, 1'b1, 16'h0049, 16'h0000, 1, "ddr_wr_49");
        drain("dsp_busy");
        n_checks++;
        if (dsp_data !== 8'h48) $display("FAIL ddr_drop: got dsp_data=%h, required 48", dsp_data);
        else n_pass++;
        @(posedge clk); #1;
        dsp_ready = 1'b1;
        @(posedge clk); #1;
        dsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dsp_valid, dsp_data} !== {1'b0, 8'h48})
            $display("FAIL dsp_drain: got valid=%b data=%h, required 0 48", dsp_valid, dsp_data);
        else
            n_pass++;
        do_req(DSR_A, 1'b0, 16'h0000, 16'h8000, 1, "dsr_ready");
        drain("dsr_ready");
    endtask

    task automatic test_mcr_unmapped();
        wen_cnt = 0;
        do_req(MCR_A, 1'b1, 16'h0000, 16'h0000, 1, "mcr_wr");
        n_checks++;
        if (halt !== 1'b1) $display("FAIL halt_ack: got halt=%b in ack cycle, required 1", halt);
        else n_pass++;
        do_req(MCR_A, 1'b0, 16'h0000, 16'h0000, 1, "mcr_rd0");
        do_req(16'hFE10, 1'b1, 16'h1234, 16'h0000, 1, "unmapped_wr");
        do_req(16'hFE10, 1'b0, 16'h0000, 16'h0000, 1, "unmapped_rd");
        drain("mcr");
        n_checks++;
        if (wen_cnt != 0) $display("FAIL mmio_no_wen: got ram_wen high for %0d cycles, required 0", wen_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        if (resp_valid) seen++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({req_ready, halt} !== 2'b10)
            $display("FAIL rst_midop_state: got req_ready/halt=%b, required 10", {req_ready, halt});
        else
            n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0) $display("FAIL rst_midop_resp: got %0d responses, required 0", seen);
        else n_pass++;
        do_req(MCR_A, 1'b0, 16'h0000, 16'h8000, 1, "mcr_after_rst");
        do_req(16'h0005, 1'b0, 16'h0000, 16'hA5CC, 2, "rd_after_rst");
        drain("after_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ram_write_read();
        test_back_to_back();
        test_keyboard();
        test_display();
        test_mcr_unmapped();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
